// File: rtl/riscv_uart_pkg.sv
// rtl/riscv_uart_pkg.sv - shared states, data-bits encoding and parity helper for the UART TX controller
package riscv_uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_state_e;

   localparam logic [1:0] DBITS_5 = 2'd0;
   localparam logic [1:0] DBITS_6 = 2'd1;
   localparam logic [1:0] DBITS_7 = 2'd2;
   localparam logic [1:0] DBITS_8 = 2'd3;

   function automatic logic [3:0] data_bits_len(input logic [1:0] enc);
      case (enc)
         DBITS_5: return 4'd5;
         DBITS_6: return 4'd6;
         DBITS_7: return 4'd7;
         DBITS_8: return 4'd8;
         default: return 4'd8;
      endcase
   endfunction

   // XOR of the low 'len' bits, inverted for odd parity.
   function automatic logic parity_bit(input logic [7:0] data, input logic [3:0] len,
                                       input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(len)) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/riscv_uart_tx_ctrl_if.sv
// rtl/riscv_uart_tx_ctrl_if.sv - byte write channel from the core store path into the TX FIFO
interface riscv_uart_tx_ctrl_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       fifo_full;
   logic       overflow;

   modport master (output tx_valid, output tx_data, input fifo_full, input overflow);
   modport slave  (input tx_valid, input tx_data, output fifo_full, output overflow);
endinterface

// File: rtl/riscv_uart_sync_fifo.sv
// rtl/riscv_uart_sync_fifo.sv - byte FIFO with wrap-bit pointers, occupancy count and overflow pulse
module riscv_uart_sync_fifo
   import riscv_uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   riscv_uart_tx_ctrl_if.slave  wr,
   input  logic                 pop,
   output logic [7:0]           rd_data,
   output logic                 empty,
   output logic [CNT_W-1:0]     count
);
   localparam int AW = CNT_W - 1;

   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       mem_q [DEPTH];
   logic             full, push, do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   assign wr.fifo_full = full;
   assign wr.overflow  = overflow_q;

   // Full is the pre-edge value, so a write into a full FIFO drops even if a pop happens now.
   assign push   = wr.tx_valid && !full;
   assign do_pop = pop && !empty;

   always_comb begin
      wr_ptr_d   = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = wr.tx_valid && full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr.tx_data;
   end

endmodule

// File: rtl/riscv_uart_tx_ctrl.sv
// rtl/riscv_uart_tx_ctrl.sv - UART transmitter: byte FIFO feeding a runtime-configurable serialiser
module riscv_uart_tx_ctrl
   import riscv_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             i_riscv_uart_clk,
   input  logic             i_riscv_uart_rst,
   input  logic             i_riscv_uart_tx_valid,
   input  logic [7:0]       i_riscv_uart_tx_data,
   input  logic             i_riscv_uart_enable,
   input  logic [DIV_W-1:0] i_riscv_uart_baud_div,
   input  logic [1:0]       i_riscv_uart_data_bits,
   input  logic             i_riscv_uart_parity_en,
   input  logic             i_riscv_uart_parity_odd,
   input  logic             i_riscv_uart_stop2,
   output logic             o_riscv_uart_fifo_full,
   output logic             o_riscv_uart_fifo_empty,
   output logic [CNT_W-1:0] o_riscv_uart_fifo_count,
   output logic             o_riscv_uart_overflow,
   output logic             o_riscv_uart_busy,
   output logic             o_riscv_uart_tx
);

   riscv_uart_tx_ctrl_if wr_if ();

   assign wr_if.tx_valid          = i_riscv_uart_tx_valid;
   assign wr_if.tx_data           = i_riscv_uart_tx_data;
   assign o_riscv_uart_fifo_full  = wr_if.fifo_full;
   assign o_riscv_uart_overflow   = wr_if.overflow;

   logic       pop;
   logic [7:0] head;
   logic       fifo_empty;

   riscv_uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk     (i_riscv_uart_clk),
      .rst_n   (i_riscv_uart_rst),
      .wr      (wr_if.slave),
      .pop     (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .count   (o_riscv_uart_fifo_count)
   );

   assign o_riscv_uart_fifo_empty = fifo_empty;

   uart_state_e      state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       nbits_q, nbits_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic             stop2_q, stop2_d;
   logic             tx_q, tx_d;

   logic bit_done, start_ok, launch;

   assign bit_done = (baud_cnt_q == div_q);
   assign start_ok = !fifo_empty && i_riscv_uart_enable;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      baud_cnt_d = baud_cnt_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      nbits_d    = nbits_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      tx_d       = tx_q;
      launch     = 1'b0;
      pop        = 1'b0;

      if (state_q != IDLE) baud_cnt_d = bit_done ? '0 : baud_cnt_q + 1'b1;

      case (state_q)
         IDLE: launch = start_ok;
         START: begin
            if (bit_done) begin
               state_d   = DATA;
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_cnt_q == nbits_q - 4'd1) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
                  tx_d      = par_en_q ? par_bit_q : 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d   = STOP;
               tx_d      = 1'b1;
               bit_cnt_d = '0;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (stop2_q && bit_cnt_q == 4'd0) begin
                  bit_cnt_d = 4'd1;
               end else if (start_ok) begin
                  launch = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Configuration is sampled only here, so mid-frame changes wait for the next frame.
      if (launch) begin
         pop        = 1'b1;
         state_d    = START;
         shift_d    = head;
         div_d      = i_riscv_uart_baud_div;
         nbits_d    = data_bits_len(i_riscv_uart_data_bits);
         par_en_d   = i_riscv_uart_parity_en;
         par_bit_d  = parity_bit(head, data_bits_len(i_riscv_uart_data_bits),
                                 i_riscv_uart_parity_odd);
         stop2_d    = i_riscv_uart_stop2;
         bit_cnt_d  = '0;
         baud_cnt_d = '0;
         tx_d       = 1'b0;
      end
   end

   always_ff @(posedge i_riscv_uart_clk or negedge i_riscv_uart_rst) begin
      if (!i_riscv_uart_rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         baud_cnt_q <= '0;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         nbits_q    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         nbits_q    <= nbits_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         tx_q       <= tx_d;
      end
   end

   assign o_riscv_uart_busy = (state_q != IDLE);
   assign o_riscv_uart_tx   = tx_q;

endmodule

// File: tb/tb_riscv_uart_tx_ctrl.sv
// tb/tb_riscv_uart_tx_ctrl.sv - scoreboard bench for the UART TX controller
module tb_riscv_uart_tx_ctrl;
   localparam int DEPTH = 4;
   localparam int DIV_W = 16;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riscv_uart_tx_ctrl_if bus ();

   logic             enable;
   logic [DIV_W-1:0] baud_div;
   logic [1:0]       data_bits;
   logic             par_en, par_odd, stop2;
   logic             empty, busy, tx;
   logic [CNT_W-1:0] count;

   riscv_uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .i_riscv_uart_clk        (clk),
      .i_riscv_uart_rst        (rst_n),
      .i_riscv_uart_tx_valid   (bus.tx_valid),
      .i_riscv_uart_tx_data    (bus.tx_data),
      .i_riscv_uart_enable     (enable),
      .i_riscv_uart_baud_div   (baud_div),
      .i_riscv_uart_data_bits  (data_bits),
      .i_riscv_uart_parity_en  (par_en),
      .i_riscv_uart_parity_odd (par_odd),
      .i_riscv_uart_stop2      (stop2),
      .o_riscv_uart_fifo_full  (bus.fifo_full),
      .o_riscv_uart_fifo_empty (empty),
      .o_riscv_uart_fifo_count (count),
      .o_riscv_uart_overflow   (bus.overflow),
      .o_riscv_uart_busy       (busy),
      .o_riscv_uart_tx         (tx)
   );

   typedef struct {
      logic [7:0] data;
      int         nbits;
      bit         pen;
      bit         podd;
      bit         s2;
      int         div;
   } frame_t;

   frame_t exp_q[$];
   int     start_cyc[$];
   int     cyc = 0;
   int     tests = 0;
   int     fails = 0;
   bit     mon_active = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void frame_bits(input frame_t f, output bit b[$]);
      int ones;
      ones = 0;
      b = {};
      b.push_back(1'b0);
      for (int i = 0; i < f.nbits; i++) begin
         b.push_back(f.data[i]);
         ones += int'(f.data[i]);
      end
      if (f.pen) b.push_back(bit'(ones & 1) ^ f.podd);
      b.push_back(1'b1);
      if (f.s2) b.push_back(1'b1);
   endfunction

   task automatic set_cfg(input int div, input int dbits, input bit pe, input bit po, input bit s2);
      baud_div  = DIV_W'(div);
      data_bits = 2'(dbits);
      par_en    = pe;
      par_odd   = po;
      stop2     = s2;
   endtask

   task automatic push_exp(input logic [7:0] d);
      frame_t f;
      f.data  = d;
      f.nbits = int'(data_bits) + 5;
      f.pen   = par_en;
      f.podd  = par_odd;
      f.s2    = stop2;
      f.div   = int'(baud_div);
      exp_q.push_back(f);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < limit && !(busy === 1'b0 && empty === 1'b1 && exp_q.size() == 0 && !mon_active));
      chk("drain_in_time", n < limit, 1);
   endtask

   task automatic single(input logic [7:0] d, input int exp_len, input string nm);
      int n;
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      push_exp(d);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk({nm, "_count_after_write"}, count, 1);
      chk({nm, "_empty_after_write"}, empty, 0);
      chk({nm, "_tx_idle_at_k"}, tx, 1);
      @(negedge clk);
      chk({nm, "_tx_start_at_k1"}, tx, 0);
      chk({nm, "_busy_at_k1"}, busy, 1);
      chk({nm, "_count_after_pop"}, count, 0);
      n = 1;
      while (busy === 1'b1 && n < 1000) begin
         @(negedge clk);
         if (busy === 1'b1) n++;
      end
      chk({nm, "_busy_len"}, n, exp_len);
      wait_drain(200);
   endtask

   // Monitor: each falling edge of an idle line must match the next queued frame.
   initial begin : monitor
      frame_t f;
      bit     bits[$];
      bit     bad, aborted;
      logic   got;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_start", 1, 0);
               for (int w = 0; w < 1000 && tx !== 1'b1; w++) @(negedge clk);
            end else begin
               f = exp_q.pop_front();
               start_cyc.push_back(cyc);
               mon_active = 1'b1;
               frame_bits(f, bits);
               aborted = 1'b0;
               for (int b = 0; b < bits.size(); b++) begin
                  bad = 1'b0;
                  got = bits[b];
                  for (int c = 0; c <= f.div; c++) begin
                     if (!(b == 0 && c == 0)) @(negedge clk);
                     if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                     end
                     if (!bad && (tx !== bits[b] || busy !== 1'b1)) begin
                        bad = 1'b1;
                        got = tx;
                     end
                  end
                  if (aborted) break;
                  chk($sformatf("frame_%02h_bit%0d", f.data, b), {31'd0, got}, {31'd0, bits[b]});
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int   n, bad;
      logic [7:0] d;

      // Reset with random inputs.
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         bus.tx_valid = 1'($urandom);
         bus.tx_data  = 8'($urandom);
         enable       = 1'($urandom);
         set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom));
      end
      chk("rst_tx", tx, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", bus.fifo_full, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", bus.overflow, 0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      enable       = 1'b1;
      rst_n        = 1'b1;

      set_cfg(3, 3, 0, 0, 0);
      single(8'h55, 40, "8n1");
      set_cfg(1, 2, 1, 0, 1);
      single(8'h41, 22, "7e2");
      set_cfg(1, 0, 1, 1, 0);
      single(8'h1F, 16, "5o1");

      // Fill a 4-deep FIFO with the serialiser gated off, then overflow it.
      set_cfg(1, 3, 0, 0, 0);
      enable = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         bus.tx_valid = 1'b1;
         bus.tx_data  = 8'(i);
         if (i <= 4) push_exp(8'(i));
         if (i > 1) begin
            chk($sformatf("fill_count_%0d", i - 1), count, (i - 1 > 4) ? 4 : i - 1);
            chk($sformatf("fill_full_%0d", i - 1), bus.fifo_full, (i - 1 >= 4) ? 1 : 0);
            chk($sformatf("fill_overflow_%0d", i - 1), bus.overflow, 0);
         end
      end
      @(negedge clk);
      chk("ovf_count", count, 4);
      chk("ovf_full", bus.fifo_full, 1);
      chk("ovf_pulse", bus.overflow, 1);
      // Write again on the edge where the first pop happens: still dropped.
      bus.tx_data = 8'h06;
      enable = 1'b1;
      start_cyc.delete();
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk("pop_write_overflow", bus.overflow, 1);
      chk("pop_write_count", count, 3);
      chk("pop_write_full", bus.fifo_full, 0);
      chk("pop_write_busy", busy, 1);
      @(negedge clk);
      chk("overflow_clears", bus.overflow, 0);
      wait_drain(2000);
      chk("b2b_frames", start_cyc.size(), 4);
      for (int i = 1; i < start_cyc.size(); i++)
         chk($sformatf("b2b_gap_%0d", i), start_cyc[i] - start_cyc[i-1], 20);

      // Random formats and bursts; single-byte bursts also disturb config mid-frame.
      for (int it = 0; it < 10; it++) begin
         set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom));
         enable = 1'b1;
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            d = 8'($urandom);
            bus.tx_valid = 1'b1;
            bus.tx_data  = d;
            push_exp(d);
         end
         @(negedge clk);
         bus.tx_valid = 1'b0;
         if (n == 1) begin
            repeat (3) @(negedge clk);
            set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom));
            enable = 1'b0;
         end
         wait_drain(2000);
         enable = 1'b1;
      end

      // Reset in the middle of a data bit with two bytes still queued.
      set_cfg(3, 3, 0, 0, 0);
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.tx_valid = 1'b1;
         bus.tx_data  = 8'hA0 + 8'(k);
         push_exp(8'hA0 + 8'(k));
      end
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_count", count, 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_count", count, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_empty", empty, 1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("quiet_after_reset_bad_cycles", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
